// File: rtl/quad_coeff_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : quad_coeff_sequencer_if
// Description : Single-word AXI-stream bundle (tdata/tvalid/tready/tlast)
//               used for the serial coefficient input and the three
//               per-coefficient output channels of quad_coeff_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface quad_coeff_sequencer_if #(
    parameter int SIZE = 64
) ();
    logic [SIZE-1:0] tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    // Producer side of the stream.
    modport master (output tdata, output tvalid, output tlast, input tready);
    // Consumer side of the stream.
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/quad_coeff_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : quad_coeff_sequencer
// Description : Collects a serial a,b,c coefficient triple (tlast on c) and
//               fans it out on three independently handshaked stream
//               channels. Malformed framing discards the partial triple and
//               is counted. Optional macro SKIP_DEGENERATE_EN drops triples
//               whose a is +/-0.0 and counts them on degen_count instead.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_coeff_sequencer #(
    parameter int SIZE  = 64,
    parameter int CNT_W = 32
) (
    input  wire logic               aclk,
    input  wire logic               aresetn,
    quad_coeff_sequencer_if.slave   s_axis,
    quad_coeff_sequencer_if.master  m_axis_a,
    quad_coeff_sequencer_if.master  m_axis_b,
    quad_coeff_sequencer_if.master  m_axis_c,
    output logic [CNT_W-1:0]        triple_count,
    output logic [CNT_W-1:0]        frame_err_count,
    output logic                    frame_err
`ifdef SKIP_DEGENERATE_EN
    ,
    output logic [CNT_W-1:0]        degen_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        GET_C = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t          state;
    logic [SIZE-1:0] a_hold;
    logic [SIZE-1:0] b_hold;
    logic [SIZE-1:0] c_hold;
    logic            in_ready;
    logic            a_valid;
    logic            b_valid;
    logic            c_valid;
    logic            a_done;
    logic            b_done;
    logic            c_done;

    logic in_fire;
    logic a_fire;
    logic b_fire;
    logic c_fire;
    logic all_done;

    assign in_fire  = s_axis.tvalid & in_ready;
    assign a_fire   = a_valid & m_axis_a.tready;
    assign b_fire   = b_valid & m_axis_b.tready;
    assign c_fire   = c_valid & m_axis_c.tready;
    // True when this cycle completes the last outstanding channel.
    assign all_done = (a_done | a_fire) & (b_done | b_fire) & (c_done | c_fire);

`ifdef SKIP_DEGENERATE_EN
    logic a_is_zero;
    // Exponent and mantissa zero means +/-0.0; the sign bit is ignored.
    assign a_is_zero = (a_hold[SIZE-2:0] == '0);
`endif

    // Holding registers drive tdata directly; they never change in ISSUE.
    assign s_axis.tready   = in_ready;
    assign m_axis_a.tdata  = a_hold;
    assign m_axis_b.tdata  = b_hold;
    assign m_axis_c.tdata  = c_hold;
    assign m_axis_a.tvalid = a_valid;
    assign m_axis_b.tvalid = b_valid;
    assign m_axis_c.tvalid = c_valid;
    // Each coefficient is a complete one-word packet on its channel.
    assign m_axis_a.tlast  = 1'b1;
    assign m_axis_b.tlast  = 1'b1;
    assign m_axis_c.tlast  = 1'b1;

    // Capture FSM, issue tracking and event counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= GET_A;
            a_hold          <= '0;
            b_hold          <= '0;
            c_hold          <= '0;
            in_ready        <= 1'b0;
            a_valid         <= 1'b0;
            b_valid         <= 1'b0;
            c_valid         <= 1'b0;
            a_done          <= 1'b0;
            b_done          <= 1'b0;
            c_done          <= 1'b0;
            triple_count    <= '0;
            frame_err_count <= '0;
            frame_err       <= 1'b0;
`ifdef SKIP_DEGENERATE_EN
            degen_count     <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (state)
                GET_A: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        a_hold <= s_axis.tdata;
                        if (s_axis.tlast) begin
                            frame_err       <= 1'b1;
                            frame_err_count <= frame_err_count + CNT_ONE;
                        end else begin
                            state <= GET_B;
                        end
                    end
                end
                GET_B: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        b_hold <= s_axis.tdata;
                        if (s_axis.tlast) begin
                            frame_err       <= 1'b1;
                            frame_err_count <= frame_err_count + CNT_ONE;
                            state           <= GET_A;
                        end else begin
                            state <= GET_C;
                        end
                    end
                end
                GET_C: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        c_hold <= s_axis.tdata;
                        if (!s_axis.tlast) begin
                            frame_err       <= 1'b1;
                            frame_err_count <= frame_err_count + CNT_ONE;
                            state           <= GET_A;
                        end else
`ifdef SKIP_DEGENERATE_EN
                        if (a_is_zero) begin
                            degen_count <= degen_count + CNT_ONE;
                            state       <= GET_A;
                        end else
`endif
                        begin
                            state    <= ISSUE;
                            in_ready <= 1'b0;
                            a_valid  <= 1'b1;
                            b_valid  <= 1'b1;
                            c_valid  <= 1'b1;
                            a_done   <= 1'b0;
                            b_done   <= 1'b0;
                            c_done   <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (a_fire) begin
                        a_valid <= 1'b0;
                        a_done  <= 1'b1;
                    end
                    if (b_fire) begin
                        b_valid <= 1'b0;
                        b_done  <= 1'b1;
                    end
                    if (c_fire) begin
                        c_valid <= 1'b0;
                        c_done  <= 1'b1;
                    end
                    if (all_done) begin
                        triple_count <= triple_count + CNT_ONE;
                        state        <= GET_A;
                        in_ready     <= 1'b1;
                        a_done       <= 1'b0;
                        b_done       <= 1'b0;
                        c_done       <= 1'b0;
                    end
                end
                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_coeff_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_coeff_sequencer
// Description : Directed, table-driven bench for quad_coeff_sequencer plus
//               hand-written reset-in-ISSUE and degenerate-a sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_coeff_sequencer;

    localparam int SIZE  = 64;
    localparam int CNT_W = 32;

    localparam logic [63:0] Z   = 64'h0000000000000000;
    localparam logic [63:0] ONE = 64'h3FF0000000000000;
    localparam logic [63:0] M3  = 64'hC008000000000000;
    localparam logic [63:0] TWO = 64'h4000000000000000;
    localparam logic [63:0] NZ  = 64'h8000000000000000;

    logic aclk;
    logic aresetn;
    logic [CNT_W-1:0] triple_count;
    logic [CNT_W-1:0] frame_err_count;
    logic             frame_err;
`ifdef SKIP_DEGENERATE_EN
    logic [CNT_W-1:0] degen_count;
`endif

    quad_coeff_sequencer_if #(.SIZE(SIZE)) s_axis   ();
    quad_coeff_sequencer_if #(.SIZE(SIZE)) m_axis_a ();
    quad_coeff_sequencer_if #(.SIZE(SIZE)) m_axis_b ();
    quad_coeff_sequencer_if #(.SIZE(SIZE)) m_axis_c ();

    quad_coeff_sequencer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis          (s_axis),
        .m_axis_a        (m_axis_a),
        .m_axis_b        (m_axis_b),
        .m_axis_c        (m_axis_c),
        .triple_count    (triple_count),
        .frame_err_count (frame_err_count),
        .frame_err       (frame_err)
`ifdef SKIP_DEGENERATE_EN
        ,
        .degen_count     (degen_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic        v, l, ra, rb, rc;
        logic        e_rdy, e_va, e_vb, e_vc;
        logic [63:0] e_ad, e_bd, e_cd;
        int          e_tc;
        logic        e_fe;
        int          e_fec;
    } vec_t;

    vec_t vecs [28];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic [63:0] data, logic v, logic l,
                                logic ra, logic rb, logic rc,
                                logic e_rdy, logic e_va, logic e_vb, logic e_vc,
                                logic [63:0] e_ad, logic [63:0] e_bd, logic [63:0] e_cd,
                                int e_tc, logic e_fe, int e_fec);
        vec_t r;
        r.data = data; r.v = v; r.l = l; r.ra = ra; r.rb = rb; r.rc = rc;
        r.e_rdy = e_rdy; r.e_va = e_va; r.e_vb = e_vb; r.e_vc = e_vc;
        r.e_ad = e_ad; r.e_bd = e_bd; r.e_cd = e_cd;
        r.e_tc = e_tc; r.e_fe = e_fe; r.e_fec = e_fec;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] data, input logic v, input logic l,
                         input logic ra, input logic rb, input logic rc);
        s_axis.tdata    = data;
        s_axis.tvalid   = v;
        s_axis.tlast    = l;
        m_axis_a.tready = ra;
        m_axis_b.tready = rb;
        m_axis_c.tready = rc;
    endtask

    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    initial begin
        // Row = inputs for one clock edge, expected outputs after that edge.
        vecs[0]  = mk(ONE,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     0,0,0);
        vecs[1]  = mk(M3 ,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     0,0,0);
        vecs[2]  = mk(TWO,1,1, 1,1,1, 0, 1,1,1, ONE,M3,TWO,0,0,0);
        vecs[3]  = mk(Z  ,0,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     1,0,0);
        vecs[4]  = mk(Z  ,0,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     1,0,0);
        // b held off for five cycles while a and c are accepted at once.
        vecs[5]  = mk(ONE,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     1,0,0);
        vecs[6]  = mk(M3 ,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     1,0,0);
        vecs[7]  = mk(TWO,1,1, 1,0,1, 0, 1,1,1, ONE,M3,TWO,1,0,0);
        for (int i = 8; i <= 12; i++)
            vecs[i] = mk(ONE,1,0, 1,0,1, 0, 0,1,0, Z,M3,Z, 1,0,0);
        vecs[13] = mk(ONE,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     2,0,0);
        // Pending word now accepted, then tlast on the second word.
        vecs[14] = mk(ONE,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     2,0,0);
        vecs[15] = mk(M3 ,1,1, 1,1,1, 1, 0,0,0, Z,Z,Z,     2,1,1);
        vecs[16] = mk(Z  ,0,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     2,0,1);
        vecs[17] = mk(ONE,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     2,0,1);
        vecs[18] = mk(M3 ,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     2,0,1);
        vecs[19] = mk(TWO,1,1, 1,1,1, 0, 1,1,1, ONE,M3,TWO,2,0,1);
        vecs[20] = mk(Z  ,0,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     3,0,1);
        // Third word without tlast, then a clean 1.0/2.0/1.0 triple.
        vecs[21] = mk(TWO,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     3,0,1);
        vecs[22] = mk(TWO,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     3,0,1);
        vecs[23] = mk(TWO,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     3,1,2);
        vecs[24] = mk(ONE,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     3,0,2);
        vecs[25] = mk(TWO,1,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     3,0,2);
        vecs[26] = mk(ONE,1,1, 1,1,1, 0, 1,1,1, ONE,TWO,ONE,3,0,2);
        vecs[27] = mk(Z  ,0,0, 1,1,1, 1, 0,0,0, Z,Z,Z,     4,0,2);

        aresetn = 1'b0;
        drive(Z, 0, 0, 1, 1, 1);
        repeat (3) @(negedge aclk);

        check("rst_tready", {63'd0, s_axis.tready}, 64'd0);
        check("rst_valids", {61'd0, m_axis_a.tvalid, m_axis_b.tvalid, m_axis_c.tvalid}, 64'd0);
        check("rst_tdata_a", m_axis_a.tdata, Z);
        check("rst_triple_count", {32'd0, triple_count}, 64'd0);
        check("rst_frame_err_count", {32'd0, frame_err_count}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);

        aresetn = 1'b1;
        step();
        check("post_rst_tready", {63'd0, s_axis.tready}, 64'd1);

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].data, vecs[i].v, vecs[i].l, vecs[i].ra, vecs[i].rb, vecs[i].rc);
            step();
            check($sformatf("v%0d_tready", i), {63'd0, s_axis.tready}, {63'd0, vecs[i].e_rdy});
            check($sformatf("v%0d_a_tvalid", i), {63'd0, m_axis_a.tvalid}, {63'd0, vecs[i].e_va});
            check($sformatf("v%0d_b_tvalid", i), {63'd0, m_axis_b.tvalid}, {63'd0, vecs[i].e_vb});
            check($sformatf("v%0d_c_tvalid", i), {63'd0, m_axis_c.tvalid}, {63'd0, vecs[i].e_vc});
            if (vecs[i].e_va) check($sformatf("v%0d_a_tdata", i), m_axis_a.tdata, vecs[i].e_ad);
            if (vecs[i].e_vb) check($sformatf("v%0d_b_tdata", i), m_axis_b.tdata, vecs[i].e_bd);
            if (vecs[i].e_vc) check($sformatf("v%0d_c_tdata", i), m_axis_c.tdata, vecs[i].e_cd);
            check($sformatf("v%0d_triple_count", i), {32'd0, triple_count}, 64'(vecs[i].e_tc));
            check($sformatf("v%0d_frame_err", i), {63'd0, frame_err}, {63'd0, vecs[i].e_fe});
            check($sformatf("v%0d_frame_err_count", i), {32'd0, frame_err_count}, 64'(vecs[i].e_fec));
        end

        // Reset asserted while b is still outstanding in ISSUE.
        drive(ONE, 1, 0, 1, 0, 1); step();
        drive(M3 , 1, 0, 1, 0, 1); step();
        drive(TWO, 1, 1, 1, 0, 1); step();
        drive(Z  , 0, 0, 1, 0, 1); step();
        check("issue_b_pending", {61'd0, m_axis_a.tvalid, m_axis_b.tvalid, m_axis_c.tvalid}, 64'b010);
        aresetn = 1'b0;
        #1;
        check("midrst_valids", {61'd0, m_axis_a.tvalid, m_axis_b.tvalid, m_axis_c.tvalid}, 64'd0);
        check("midrst_triple_count", {32'd0, triple_count}, 64'd0);
        check("midrst_frame_err_count", {32'd0, frame_err_count}, 64'd0);
        check("midrst_tready", {63'd0, s_axis.tready}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        step();
        check("midrst_release_tready", {63'd0, s_axis.tready}, 64'd1);
        check("midrst_release_valids", {61'd0, m_axis_a.tvalid, m_axis_b.tvalid, m_axis_c.tvalid}, 64'd0);

`ifdef SKIP_DEGENERATE_EN
        // a = -0.0 must be dropped rather than issued.
        drive(NZ , 1, 0, 1, 1, 1); step();
        drive(ONE, 1, 0, 1, 1, 1); step();
        drive(ONE, 1, 1, 1, 1, 1); step();
        check("degen_valids", {61'd0, m_axis_a.tvalid, m_axis_b.tvalid, m_axis_c.tvalid}, 64'd0);
        check("degen_tready", {63'd0, s_axis.tready}, 64'd1);
        check("degen_count", {32'd0, degen_count}, 64'd1);
        check("degen_triple_count", {32'd0, triple_count}, 64'd0);
        drive(Z, 0, 0, 1, 1, 1); step();
        check("degen_idle_valids", {61'd0, m_axis_a.tvalid, m_axis_b.tvalid, m_axis_c.tvalid}, 64'd0);
`else
        // Same a = -0.0 triple is a normal triple without the skip feature.
        drive(NZ , 1, 0, 1, 1, 1); step();
        drive(ONE, 1, 0, 1, 1, 1); step();
        drive(ONE, 1, 1, 1, 1, 1); step();
        check("negzero_valids", {61'd0, m_axis_a.tvalid, m_axis_b.tvalid, m_axis_c.tvalid}, 64'b111);
        check("negzero_a_tdata", m_axis_a.tdata, NZ);
        drive(Z, 0, 0, 1, 1, 1); step();
        check("negzero_triple_count", {32'd0, triple_count}, 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quad_coeff_sequencer.md
Name: quad_coeff_sequencer

Overview:
- Upstream feeder for the quadratic solver.
- Accepts one serial AXI-stream of 64-bit floats ordered a, b, c, with tlast on c.
- Fans each complete triple out to three independent AXI-stream master channels (a, b, c) wired directly to the solver's three slave ports.
- Each output channel handshakes independently, since the solver's channels do not share a common ready.

Parameters:
- SIZE, 64, float word width (IEEE-754 double for 64).
- CNT_W, 32, width of the triple and error counters.

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- s_axis_tdata  input  SIZE  serial coefficient word
- s_axis_tvalid  input  1  input word valid
- s_axis_tready  output  1  sequencer can accept a word
- s_axis_tlast  input  1  marks the c word of a triple
- m_axis_a_tdata  output  SIZE  coefficient a
- m_axis_a_tvalid  output  1  a valid
- m_axis_a_tready  input  1  a accepted by downstream
- m_axis_b_tdata  output  SIZE  coefficient b
- m_axis_b_tvalid  output  1  b valid
- m_axis_b_tready  input  1  b accepted
- m_axis_c_tdata  output  SIZE  coefficient c
- m_axis_c_tvalid  output  1  c valid
- m_axis_c_tready  input  1  c accepted
- triple_count  output  CNT_W  triples fully issued (all three channels accepted)
- frame_err_count  output  CNT_W  framing errors detected
- frame_err  output  1  one-cycle pulse on a framing error

Behaviour:
- Single clock aclk; reset is asynchronous and active-low on aresetn.
- Reset values: state = GET_A; all m_*_tvalid = 0; all tdata = 0; s_axis_tready = 0 during reset, 1 in the first cycle after release; both counters = 0; frame_err = 0.
- States: GET_A, GET_B, GET_C, ISSUE.
- s_axis_tready = 1 in GET_A/GET_B/GET_C; 0 in ISSUE.
- An input handshake (tvalid & tready) in GET_A/GET_B/GET_C captures tdata into the a/b/c holding register.
- GET_A, GET_B transitions:
  - Handshake with tlast = 0: advance GET_A->GET_B, GET_B->GET_C.
  - Handshake with tlast = 1: framing error. Discard the partial triple, pulse frame_err, increment frame_err_count, go to GET_A.
- GET_C transitions:
  - Handshake with tlast = 1: go to ISSUE. All three m_*_tvalid rise the next cycle, so latency is 1 cycle from the c-word handshake to valid.
  - Handshake with tlast = 0: framing error. Discard the word, pulse frame_err, increment frame_err_count, go to GET_A.
- ISSUE:
  - Each channel holds tvalid high and tdata stable until its own tready is seen, then deasserts tvalid the following cycle.
  - Per-channel "done" flags track acceptance.
  - When the last outstanding channel handshakes (including all three in the same cycle), increment triple_count and go to GET_A. s_axis_tready is 1 on the next cycle.
  - tvalid never drops without a handshake; tdata never changes while tvalid is high.
- Throughput: at best one triple per 4 cycles (3 input cycles + 1 issue cycle).
- Counters wrap modulo 2^CNT_W without saturation.
- Reset asserted mid-triple or mid-issue:
  - Immediately clears state, valids, flags, and counters.
  - No partial triple is ever issued after reset.

Optional Feature:
- Macro SKIP_DEGENERATE_EN.
- Defined:
  - In GET_C, on a valid triple, if the captured a has exponent and mantissa both zero (±0.0, sign ignored), skip ISSUE and go straight to GET_A.
  - Increment an extra output degen_count (CNT_W, reset 0). triple_count is not incremented.
  - Purpose: avoids division by 2a = 0 in the solver.
- Not defined: every valid triple is issued; the degen_count port does not exist.

Test Plan:
- Triple a=0x3FF0000000000000 (1.0), b=0xC008000000000000 (-3.0), c=0x4000000000000000 (2.0), tlast on c, all readies 1 -> all three tvalid high for exactly 1 cycle, starting 1 cycle after the c handshake, with matching tdata; triple_count=1.
- Same triple, m_axis_b_tready held 0 for 5 cycles, a and c ready -> a and c valid drop after 1 cycle; b valid held 6 cycles with stable data; s_axis_tready=0 throughout; triple_count increments only on the b handshake.
- tlast asserted on the second word -> frame_err pulses 1 cycle, frame_err_count=1, no output valid; the next well-formed triple issues correctly.
- Three words with no tlast on the third -> frame_err, third word discarded; a following 1.0/2.0/1.0 triple issues with those exact values.
- aresetn dropped while in ISSUE with b not yet accepted -> all valids 0 immediately, counters 0, s_axis_tready=1 the cycle after release.
- With SKIP_DEGENERATE_EN: triple a=0x8000000000000000 (-0.0), b=1.0, c=1.0 -> no output valid, degen_count=1, triple_count unchanged.
